// File: rtl/pixel_preproc_stage.sv
// Pixel pre-processing stage: RGB channel expansion, gray/luma/binary conversion on a
// 2-deep valid/ready pipeline, frame counter and a frame-level detection debouncer.
module pixel_preproc_stage #(
    parameter int CW         = 4,
    parameter int ON_FRAMES  = 3,
    parameter int OFF_FRAMES = 5,
    parameter int FCNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode_sel,
    input  logic [7:0]        thresh,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [3*CW-1:0]   x_data,
    input  logic              x_sop,
    input  logic              x_eop,
    output logic              y_valid,
    input  logic              y_ready,
    output logic [3*CW-1:0]   y_data,
    output logic [7:0]        y_gray,
    output logic              y_sop,
    output logic              y_eop,
    input  logic              det_in,
    input  logic              det_valid,
    output logic              stop_flag,
    output logic [FCNT_W-1:0] frame_count
);
    localparam int CMAX  = (ON_FRAMES > OFF_FRAMES) ? ON_FRAMES : OFF_FRAMES;
    localparam int CNT_W = $clog2(CMAX + 1);

    // MSB replication: the top CW bits of the result equal the original channel.
    function automatic logic [7:0] expand(input logic [CW-1:0] c);
        return 8'({c, c} >> (2*CW - 8));
    endfunction

    logic       en, accept;
    logic [1:0] mode_act, beat_mode;

    assign en        = ~y_valid | y_ready;
    assign x_ready   = en;
    assign accept    = x_valid & en;
    assign beat_mode = (accept && x_sop) ? mode_sel : mode_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mode_act <= 2'd0;
        else if (accept && x_sop)
            mode_act <= mode_sel;
    end

    // Stage 1: expanded channels plus the mode/threshold that travel with the beat.
    logic       s1_valid, s1_sop, s1_eop;
    logic [7:0] s1_r, s1_g, s1_b, s1_thresh;
    logic [1:0] s1_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sop    <= 1'b0;
            s1_eop    <= 1'b0;
            s1_r      <= 8'd0;
            s1_g      <= 8'd0;
            s1_b      <= 8'd0;
            s1_thresh <= 8'd0;
            s1_mode   <= 2'd0;
        end else if (en) begin
            s1_valid  <= x_valid;
            s1_sop    <= x_sop;
            s1_eop    <= x_eop;
            s1_r      <= expand(x_data[3*CW-1:2*CW]);
            s1_g      <= expand(x_data[2*CW-1:CW]);
            s1_b      <= expand(x_data[CW-1:0]);
            s1_thresh <= thresh;
            s1_mode   <= beat_mode;
        end
    end

    // Stage 2 combinational conversion
    logic [9:0]      sum10;
    logic [17:0]     luma18;
    logic [7:0]      avg, luma, g_sel, out_gray;
    logic [3*CW-1:0] out_data;

    assign sum10  = {2'b00, s1_r} + {2'b00, s1_g} + {2'b00, s1_b};
    assign avg    = 8'(sum10 / 10'd3);
    assign luma18 = 18'd77 * 18'(s1_r) + 18'd150 * 18'(s1_g) + 18'd29 * 18'(s1_b);
    assign luma   = 8'(luma18 >> 8);

    always_comb begin
        g_sel    = avg;
        out_gray = avg;
        out_data = {s1_r[7:8-CW], s1_g[7:8-CW], s1_b[7:8-CW]};
        case (s1_mode)
            2'd1:    g_sel = avg;
            2'd2:    g_sel = luma;
            2'd3:    g_sel = (luma >= s1_thresh) ? 8'hFF : 8'h00;
            default: g_sel = avg;
        endcase
        if (s1_mode != 2'd0) begin
            out_gray = g_sel;
            out_data = {3{g_sel[7:8-CW]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            y_gray  <= 8'd0;
            y_sop   <= 1'b0;
            y_eop   <= 1'b0;
        end else if (en) begin
            y_valid <= s1_valid;
            y_data  <= out_data;
            y_gray  <= out_gray;
            y_sop   <= s1_sop;
            y_eop   <= s1_eop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_count <= '0;
        else if (y_valid && y_ready && y_eop)
            frame_count <= frame_count + FCNT_W'(1);
    end

    // Detection debouncer: hysteresis counted in frames, advanced only on det_valid.
    typedef enum logic [1:0] {CLEAR, ARMING, STOP, RELEASING} dstate_t;
    dstate_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            stop_flag <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stop_flag <= (state_d == STOP) || (state_d == RELEASING);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (det_valid) begin
            case (state_q)
                CLEAR: if (det_in) begin
                    if (ON_FRAMES == 1) begin
                        state_d = STOP;
                        cnt_d   = '0;
                    end else begin
                        state_d = ARMING;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ARMING: begin
                    if (!det_in) begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_W'(ON_FRAMES)) begin
                        state_d = STOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                STOP: if (!det_in) begin
                    if (OFF_FRAMES == 1) begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                    end else begin
                        state_d = RELEASING;
                        cnt_d   = CNT_W'(1);
                    end
                end
                RELEASING: begin
                    if (det_in) begin
                        state_d = STOP;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_W'(OFF_FRAMES)) begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                default: begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule
